// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Define IMM_ALU_OPS_EN to enable addi/andi/ori/slti decode.
module multicycle_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] mem_op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Inm,
  output logic [3:0] ALUOpFinal,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    INIT      = 4'd12
  } st_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  st_t        cur;
  st_t        dec_nxt;
  logic [5:0] opc;
  logic       is_r;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_j;
  logic       is_imm;
  logic       legal;
  logic [3:0] imm_code;

  assign is_r   = (opc == OP_R);
  assign is_lw  = (opc == OP_LW);
  assign is_sw  = (opc == OP_SW);
  assign is_beq = (opc == OP_BEQ);
  assign is_j   = (opc == OP_J);

`ifdef IMM_ALU_OPS_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  always_comb begin
    is_imm   = 1'b1;
    imm_code = 4'b0000;
    unique case (opc)
      OP_ADDI: imm_code = 4'b0010;
      OP_ANDI: imm_code = 4'b0000;
      OP_ORI:  imm_code = 4'b0001;
      OP_SLTI: imm_code = 4'b0111;
      default: is_imm   = 1'b0;
    endcase
  end
`else
  assign is_imm   = 1'b0;
  assign imm_code = 4'b0000;
`endif

  assign legal = is_r | is_lw | is_sw
               | is_beq | is_j | is_imm;

  always_comb begin
    dec_nxt = FETCH;
    unique case (1'b1)
      is_r:          dec_nxt = R_EXEC;
      is_lw | is_sw: dec_nxt = MEM_ADDR;
      is_beq:        dec_nxt = BRANCH;
      is_j:          dec_nxt = JUMP;
      is_imm:        dec_nxt = I_EXEC;
      default:       dec_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= INIT;
      opc <= 6'b000000;
    end else begin
      case (cur)
        INIT:  cur <= FETCH;
        FETCH: if (mem_ready) begin
          cur <= DECODE;
          opc <= mem_op;
        end
        DECODE:   cur <= dec_nxt;
        MEM_ADDR: cur <= is_lw ? MEM_READ
                                : MEM_WRITE;
        MEM_READ:  if (mem_ready) cur <= MEM_WB;
        MEM_WRITE: if (mem_ready) cur <= FETCH;
        R_EXEC:    cur <= R_WB;
        I_EXEC:    cur <= I_WB;
        // write-backs, branch, jump and stray codes
        default:   cur <= FETCH;
      endcase
    end
  end

  assign state = cur;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    Inm         = 1'b0;
    ALUOpFinal  = 4'b0000;
    illegal_op  = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~legal;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef IMM_ALU_OPS_EN
      I_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        Inm        = 1'b1;
        ALUOpFinal = imm_code;
      end
      I_WB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control.
// Honours IMM_ALU_OPS_EN in its reference model.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] mem_op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead;
  logic       MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic       RegWrite, RegDst, Inm, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] ALUOpFinal, state;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n),
    .mem_op(mem_op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Inm(Inm),
    .ALUOpFinal(ALUOpFinal),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {state, 10 enables, PCSource, ALUSrcB, ALUOp, Inm, ALUOpFinal, illegal}
  logic [25:0] act;
  assign act = {state, PCWrite, PCWriteCond, IorD,
                MemRead, MemWrite, IRWrite, MemtoReg,
                ALUSrcA, RegWrite, RegDst, PCSource,
                ALUSrcB, ALUOp, Inm, ALUOpFinal,
                illegal_op};

  logic [25:0] qv[$];
  string       qn[$];
  int total = 0;
  int bad = 0;
  bit done = 0;

  function automatic bit imm_op(input logic [5:0] op);
`ifdef IMM_ALU_OPS_EN
    return op == 6'd8 || op == 6'd12 ||
           op == 6'd13 || op == 6'd10;
`else
    return (op != op);
`endif
  endfunction

  function automatic logic [3:0] imm_fn(input logic [5:0] op);
    case (op)
      6'd8:    return 4'd2;
      6'd12:   return 4'd0;
      6'd13:   return 4'd1;
      6'd10:   return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'd0 || op == 6'd35 || op == 6'd43 ||
           op == 6'd4 || op == 6'd2 || imm_op(op);
  endfunction

  // Expected outputs for a named phase of an instruction.
  function automatic logic [25:0] ev(input int st, input bit rdy,
                                     input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, irw, m2r, sa, rw, rd, inm, ill;
    logic [1:0] pcs, sb, aop;
    logic [3:0] fin;
    {pw, pwc, iord, mr, mw, irw, m2r, sa, rw, rd} = '0;
    {pcs, sb, aop, inm, fin, ill} = '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin sb = 2'b11; ill = !legal_op(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      9:  begin pw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; inm = 1; fin = imm_fn(op); end
      11: rw = 1;
      default: ;
    endcase
    return {st[3:0], pw, pwc, iord, mr, mw, irw, m2r, sa,
            rw, rd, pcs, sb, aop, inm, fin, ill};
  endfunction

  task automatic cyc(input bit rn, input logic [5:0] op,
                     input bit rdy, input logic [25:0] e,
                     input string nm);
    @(posedge clk);
    #1;
    rst_n = rn;
    mem_op = op;
    mem_ready = rdy;
    qv.push_back(e);
    qn.push_back(nm);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic fetch(input logic [5:0] op, input int w);
    for (int i = 0; i < w; i++)
      cyc(1, op, 0, ev(0, 0, op), "fetch_wait");
    cyc(1, op, 1, ev(0, 1, op), "fetch");
  endtask

  // One full instruction: fetch waits wf, memory waits wm.
  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    bit r;
    fetch(op, wf);
    cyc(1, junk(), rb(), ev(1, 0, op), "decode");
    if (!legal_op(op)) return;
    if (op == 6'd0) begin
      cyc(1, junk(), rb(), ev(6, 0, op), "r_exec");
      cyc(1, junk(), rb(), ev(7, 0, op), "r_wb");
    end else if (op == 6'd4) begin
      cyc(1, junk(), rb(), ev(8, 0, op), "branch");
    end else if (op == 6'd2) begin
      cyc(1, junk(), rb(), ev(9, 0, op), "jump");
    end else if (imm_op(op)) begin
      cyc(1, junk(), rb(), ev(10, 0, op), "i_exec");
      cyc(1, junk(), rb(), ev(11, 0, op), "i_wb");
    end else begin
      r = (op == 6'd35);
      cyc(1, junk(), rb(), ev(2, 0, op), "mem_addr");
      for (int i = 0; i < wm; i++)
        cyc(1, junk(), 0, ev(r ? 3 : 5, 0, op),
            r ? "mem_read_wait" : "mem_write_wait");
      cyc(1, junk(), 1, ev(r ? 3 : 5, 1, op),
          r ? "mem_read" : "mem_write");
      if (r) cyc(1, junk(), rb(), ev(4, 0, op), "mem_wb");
    end
  endtask

  task automatic reset_seq();
    cyc(0, junk(), rb(), ev(12, 0, 0), "reset");
    cyc(0, junk(), rb(), ev(12, 0, 0), "reset");
    cyc(1, junk(), rb(), ev(12, 0, 0), "init");
  endtask

  always @(negedge clk) begin
    if (qv.size() > 0) begin
      logic [25:0] e;
      string n;
      e = qv.pop_front();
      n = qn.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s t=%0t got=%h exp=%h", n, $time, act, e);
      end
    end
  end

  logic [5:0] ops [10];
  initial begin
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2,
            6'd8, 6'd12, 6'd13, 6'd10, 6'd63};
    reset_seq();
    instr(6'd0, 0, 0);
    instr(6'd35, 2, 2);
    instr(6'd43, 0, 1);
    instr(6'd4, 0, 0);
    instr(6'd13, 0, 0);
    instr(6'd63, 1, 0);
    // abort a load while MEM_READ sees mem_ready
    fetch(6'd35, 0);
    cyc(1, junk(), 1, ev(1, 0, 6'd35), "decode");
    cyc(1, junk(), 1, ev(2, 0, 6'd35), "mem_addr");
    cyc(1, junk(), 0, ev(3, 0, 6'd35), "mem_read_wait");
    cyc(0, junk(), 1, ev(12, 0, 0), "abort");
    cyc(0, junk(), 1, ev(12, 0, 0), "abort_hold");
    cyc(1, junk(), 1, ev(12, 0, 0), "init");
    for (int k = 0; k < 80; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 5) == 0) ? junk()
                                       : ops[$urandom_range(0, 9)];
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    done = 1;
  end

  initial begin
    wait (done || $time > 1_000_000);
    if (!done || qv.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d", qv.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
